// File: rtl/rpl_vm_pkg.sv
// Shared types for the RPL engine dispatcher: FSM states and result status codes.
package rpl_vm_pkg;

  localparam int STATUS_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_ABORT,
    S_RESPOND
  } dispatch_state_e;

  typedef enum logic [STATUS_W-1:0] {
    ST_OK      = 2'd0,
    ST_NOMATCH = 2'd1,
    ST_TIMEOUT = 2'd2
  } match_status_e;

endpackage

// File: rtl/rpl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rpl_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rpl_vm_dispatcher.sv
// Round-robin dispatcher sharing one RPL match engine among N_REQ requesters.
// Per-job cycle budget (ABORT/TIMEOUT) built only with RPL_VM_DISPATCH_TIMEOUT_EN.
module rpl_vm_dispatcher
  import rpl_vm_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PC_W  = 16,
  parameter int POS_W = 16,
  parameter int TMO_W = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*PC_W-1:0]  req_pc,
  input  logic [N_REQ*POS_W-1:0] req_pos,
  output logic                   eng_start_valid,
  input  logic                   eng_start_ready,
  output logic [PC_W-1:0]        eng_pc,
  output logic [POS_W-1:0]       eng_pos,
  input  logic                   eng_done,
  input  logic                   eng_matched,
  input  logic [POS_W-1:0]       eng_end_pos,
  output logic                   eng_abort,
  input  logic [TMO_W-1:0]       cfg_timeout,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic                   rsp_matched,
  output logic [POS_W-1:0]       rsp_pos,
  output logic [STATUS_W-1:0]    rsp_status,
  output logic                   busy
);

  localparam int IDX_W = $clog2(N_REQ);

  dispatch_state_e  state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             rsp_matched_q, rsp_matched_d;
  logic [POS_W-1:0] rsp_pos_q, rsp_pos_d;
  match_status_e    rsp_status_q, rsp_status_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;

  rpl_rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

`ifdef RPL_VM_DISPATCH_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;

  // Hitting budget-1 makes abort appear exactly cfg_timeout cycles after start.
  assign tmo_hit = (cfg_timeout != '0) && (tmo_cnt_q == cfg_timeout - TMO_W'(1));

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^cfg_timeout;
`endif

  always_comb begin
    state_d         = state_q;
    gnt_idx_d       = gnt_idx_q;
    rr_ptr_d        = rr_ptr_q;
    pc_d            = pc_q;
    pos_d           = pos_q;
    rsp_matched_d   = rsp_matched_q;
    rsp_pos_d       = rsp_pos_q;
    rsp_status_d    = rsp_status_q;
    req_ready       = '0;
    eng_start_valid = 1'b0;
    eng_abort       = 1'b0;
    rsp_valid       = '0;
`ifdef RPL_VM_DISPATCH_TIMEOUT_EN
    tmo_cnt_d       = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready = arb_gnt;
          gnt_idx_d = arb_idx;
          pc_d      = req_pc[arb_idx*PC_W +: PC_W];
          pos_d     = req_pos[arb_idx*POS_W +: POS_W];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start_valid = 1'b1;
        if (eng_start_ready) begin
`ifdef RPL_VM_DISPATCH_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
`ifdef RPL_VM_DISPATCH_TIMEOUT_EN
        if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
        if (eng_done) begin
          rsp_matched_d = eng_matched;
          rsp_pos_d     = eng_matched ? eng_end_pos : pos_q;
          rsp_status_d  = eng_matched ? ST_OK : ST_NOMATCH;
          state_d       = S_RESPOND;
        end
`ifdef RPL_VM_DISPATCH_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = S_ABORT;
        end
`endif
      end
`ifdef RPL_VM_DISPATCH_TIMEOUT_EN
      S_ABORT: begin
        eng_abort = 1'b1;
        // Whatever the engine reports after an abort is stale; report the budget miss.
        if (eng_done) begin
          rsp_matched_d = 1'b0;
          rsp_pos_d     = pos_q;
          rsp_status_d  = ST_TIMEOUT;
          state_d       = S_RESPOND;
        end
      end
`endif
      S_RESPOND: begin
        rsp_valid[gnt_idx_q] = 1'b1;
        if (rsp_ready[gnt_idx_q]) begin
          rr_ptr_d = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gnt_idx_q     <= '0;
      rr_ptr_q      <= '0;
      pc_q          <= '0;
      pos_q         <= '0;
      rsp_matched_q <= 1'b0;
      rsp_pos_q     <= '0;
      rsp_status_q  <= ST_OK;
    end else begin
      state_q       <= state_d;
      gnt_idx_q     <= gnt_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      pc_q          <= pc_d;
      pos_q         <= pos_d;
      rsp_matched_q <= rsp_matched_d;
      rsp_pos_q     <= rsp_pos_d;
      rsp_status_q  <= rsp_status_d;
    end
  end

  assign eng_pc      = pc_q;
  assign eng_pos     = pos_q;
  assign rsp_matched = rsp_matched_q;
  assign rsp_pos     = rsp_pos_q;
  assign rsp_status  = rsp_status_q;
  assign busy        = (state_q != S_IDLE);

endmodule
